// File: rtl/data_memory_requester.sv
// Core-side requester for the data memory manager: queues byte read/write requests and
// sequences address-register load, access strobe, read wait and a one-cycle response.
module data_memory_requester #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              in_rst_n,
    input  logic              in_req_valid,
    output logic              out_req_ready,
    input  logic              in_req_write,
    input  logic [ADDR_W-1:0] in_req_addr,
    input  logic [DATA_W-1:0] in_req_wdata,
    output logic              out_rsp_valid,
    output logic              out_rsp_write,
    output logic [DATA_W-1:0] out_rsp_data,
    output logic              out_mem_addr_write_en,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_mem_write_en,
    output logic              out_mem_read_en,
    output logic [DATA_W-1:0] out_mem_data,
    input  logic [DATA_W-1:0] in_mem_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_ACCESS = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    req_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    req_t              head;

    state_t            state;
    req_t              work;
    logic              cache_valid;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_hit;
    logic [LAT_W-1:0]  lat_cnt;

    // Ready derives only from the registered count, so a same-cycle pop never frees a full queue.
    assign out_req_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push          = in_req_valid && out_req_ready;
    assign pop           = (state == S_IDLE) && (count != '0);
    assign head          = fifo_mem[rd_ptr];
    assign cache_hit     = cache_valid && (head.addr == cache_addr);

    // Queue storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: in_req_write, addr: in_req_addr, wdata: in_req_wdata};
        end
    end

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control FSM; strobes are set on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state                 <= S_IDLE;
            work                  <= '0;
            cache_valid           <= 1'b0;
            cache_addr            <= '0;
            lat_cnt               <= '0;
            out_rsp_valid         <= 1'b0;
            out_rsp_write         <= 1'b0;
            out_rsp_data          <= '0;
            out_mem_addr_write_en <= 1'b0;
            out_mem_addr          <= '0;
            out_mem_write_en      <= 1'b0;
            out_mem_read_en       <= 1'b0;
            out_mem_data          <= '0;
        end else begin
            out_rsp_valid         <= 1'b0;
            out_mem_addr_write_en <= 1'b0;
            out_mem_write_en      <= 1'b0;
            out_mem_read_en       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        work <= head;
                        if (cache_hit) begin
                            state <= S_ACCESS;
                            if (head.write) begin
                                out_mem_write_en <= 1'b1;
                                out_mem_data     <= head.wdata;
                            end else begin
                                out_mem_read_en  <= 1'b1;
                            end
                        end else begin
                            state                 <= S_ADDR;
                            out_mem_addr_write_en <= 1'b1;
                            out_mem_addr          <= head.addr;
                        end
                    end
                end
                S_ADDR: begin
                    cache_valid <= 1'b1;
                    cache_addr  <= work.addr;
                    state       <= S_ACCESS;
                    if (work.write) begin
                        out_mem_write_en <= 1'b1;
                        out_mem_data     <= work.wdata;
                    end else begin
                        out_mem_read_en  <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (work.write) begin
                        state         <= S_RESP;
                        out_rsp_valid <= 1'b1;
                        out_rsp_write <= 1'b1;
                        out_rsp_data  <= '0;
                    end else begin
                        state   <= S_WAIT;
                        lat_cnt <= LAT_W'(READ_LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        state         <= S_RESP;
                        out_rsp_valid <= 1'b1;
                        out_rsp_write <= 1'b0;
                        out_rsp_data  <= in_mem_data;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_requester.sv
// Scoreboard bench for data_memory_requester with a behavioural memory manager
// (address register, byte array, 0x3FE input port, 0x3FF output port).
module tb_data_memory_requester;

    logic       clk = 1'b0;
    logic       in_rst_n;
    logic       in_req_valid;
    logic       out_req_ready;
    logic       in_req_write;
    logic [9:0] in_req_addr;
    logic [7:0] in_req_wdata;
    logic       out_rsp_valid;
    logic       out_rsp_write;
    logic [7:0] out_rsp_data;
    logic       out_mem_addr_write_en;
    logic [9:0] out_mem_addr;
    logic       out_mem_write_en;
    logic       out_mem_read_en;
    logic [7:0] out_mem_data;
    logic [7:0] in_mem_data = 8'h00;

    data_memory_requester #(
        .ADDR_W(10), .DATA_W(8), .FIFO_DEPTH(2), .READ_LATENCY(1)
    ) dut (
        .clk                  (clk),
        .in_rst_n             (in_rst_n),
        .in_req_valid         (in_req_valid),
        .out_req_ready        (out_req_ready),
        .in_req_write         (in_req_write),
        .in_req_addr          (in_req_addr),
        .in_req_wdata         (in_req_wdata),
        .out_rsp_valid        (out_rsp_valid),
        .out_rsp_write        (out_rsp_write),
        .out_rsp_data         (out_rsp_data),
        .out_mem_addr_write_en(out_mem_addr_write_en),
        .out_mem_addr         (out_mem_addr),
        .out_mem_write_en     (out_mem_write_en),
        .out_mem_read_en      (out_mem_read_en),
        .out_mem_data         (out_mem_data),
        .in_mem_data          (in_mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         w;
        logic [7:0] d;
        int         acc;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_addr_wr = 0;
    int         n_rsp = 0;
    logic [9:0] last_addr = '0;
    bit         saw_not_ready = 0;

    // Memory manager model
    logic [9:0] mem_ar = '0;
    logic [7:0] mem [1024];
    bit         written [1024];
    bit   [3:0] out_port = 4'h0;
    bit   [3:0] in_port = 4'h0;

    function automatic logic [7:0] init_val(input logic [9:0] a);
        case (a)
            10'h010: return 8'h3C;
            10'h020: return 8'h77;
            10'h001: return 8'hB1;
            10'h002: return 8'hB2;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (out_mem_addr_write_en) mem_ar <= out_mem_addr;
        if (out_mem_write_en) begin
            mem[mem_ar]     <= out_mem_data;
            written[mem_ar] <= 1'b1;
            if (mem_ar == 10'h3FF) out_port <= out_mem_data[3:0];
        end
        if (out_mem_read_en)
            in_mem_data <= (mem_ar == 10'h3FE) ? {4'h0, in_port}
                         : (written[mem_ar] ? mem[mem_ar] : init_val(mem_ar));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every response and watches strobe exclusivity.
    always @(negedge clk) begin
        exp_t e;
        if (out_mem_addr_write_en) begin
            n_addr_wr++;
            last_addr = out_mem_addr;
        end
        if (out_mem_addr_write_en || out_mem_write_en || out_mem_read_en)
            chk("strobe_onehot",
                32'($countones({out_mem_addr_write_en, out_mem_write_en, out_mem_read_en})), 32'd1);
        if (!out_req_ready) saw_not_ready = 1;
        if (out_rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_write", 32'(out_rsp_write), 32'(e.w));
                chk("rsp_data", 32'(out_rsp_data), 32'(e.d));
                if (e.lat >= 0) chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input bit w, input logic [9:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d, input int exp_lat);
        int guard = 0;
        exp_t e;
        in_req_valid = 1'b1;
        in_req_write = w;
        in_req_addr  = a;
        in_req_wdata = d;
        while (!out_req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 32'd0, 32'd1);
        e.w = w; e.d = exp_d; e.acc = cyc + 1; e.lat = exp_lat;
        exp_q.push_back(e);
        @(negedge clk);
        in_req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        in_rst_n     = 1'b0;
        in_req_valid = 1'b0;
        in_req_write = 1'b0;
        in_req_addr  = '0;
        in_req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(out_req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(out_rsp_valid), 32'd0);
        chk("reset_strobes", 32'({out_mem_addr_write_en, out_mem_write_en, out_mem_read_en}), 32'd0);
        chk("reset_mem_addr", 32'(out_mem_addr), 32'd0);
        chk("reset_rsp_data", 32'(out_rsp_data), 32'd0);
        in_rst_n = 1'b1;
        @(negedge clk);

        // 1: reset while in ADDR drops the request and leaves the cache invalid
        send(1'b0, 10'h020, 8'h00, 8'h77, 4);
        @(negedge clk);
        chk("t1_in_addr", 32'(out_mem_addr_write_en), 32'd1);
        #2 in_rst_n = 1'b0;
        #1;
        chk("t1_reset_strobes", 32'({out_mem_addr_write_en, out_mem_write_en, out_mem_read_en,
                                     out_rsp_valid}), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        in_rst_n = 1'b1;
        base = n_rsp;
        repeat (8) @(negedge clk);
        chk("t1_no_rsp_after_reset", 32'(n_rsp - base), 32'd0);
        base = n_addr_wr;
        send(1'b0, 10'h020, 8'h00, 8'h77, 4);
        drain();
        chk("t1_miss_after_reset", 32'(n_addr_wr - base), 32'd1);

        // 2: read miss
        base = n_addr_wr;
        send(1'b0, 10'h010, 8'h00, 8'h3C, 4);
        drain();
        chk("t2_addr_loads", 32'(n_addr_wr - base), 32'd1);
        chk("t2_addr", 32'(last_addr), 32'h010);

        // 3: write hit then read hit
        base = n_addr_wr;
        send(1'b1, 10'h010, 8'h5A, 8'h00, 2);
        drain();
        send(1'b0, 10'h010, 8'h00, 8'h5A, 3);
        drain();
        chk("t3_no_addr_loads", 32'(n_addr_wr - base), 32'd0);

        // 4: I/O ports through the manager
        send(1'b1, 10'h3FF, 8'hA5, 8'h00, 3);
        drain();
        chk("t4_out_port", 32'(out_port), 32'h5);
        in_port = 4'h9;
        send(1'b0, 10'h3FE, 8'h00, 8'h09, 4);
        drain();

        // 5: four back-to-back requests through a two-entry queue
        saw_not_ready = 0;
        base = n_rsp;
        send(1'b1, 10'h100, 8'h11, 8'h00, -1);
        send(1'b1, 10'h101, 8'h22, 8'h00, -1);
        send(1'b0, 10'h100, 8'h00, 8'h11, -1);
        send(1'b0, 10'h101, 8'h00, 8'h22, -1);
        drain();
        chk("t5_ready_dropped", 32'(saw_not_ready), 32'd1);
        chk("t5_rsp_count", 32'(n_rsp - base), 32'd4);

        // 6: alternating addresses miss, repeated address hits
        base = n_addr_wr;
        send(1'b0, 10'h001, 8'h00, 8'hB1, 4); drain();
        chk("t6_miss_a", 32'(n_addr_wr - base), 32'd1);
        send(1'b0, 10'h002, 8'h00, 8'hB2, 4); drain();
        chk("t6_miss_b", 32'(n_addr_wr - base), 32'd2);
        send(1'b0, 10'h001, 8'h00, 8'hB1, 4); drain();
        chk("t6_miss_c", 32'(n_addr_wr - base), 32'd3);
        send(1'b0, 10'h002, 8'h00, 8'hB2, 4); drain();
        chk("t6_miss_d", 32'(n_addr_wr - base), 32'd4);
        send(1'b0, 10'h002, 8'h00, 8'hB2, 3); drain();
        chk("t6_hit", 32'(n_addr_wr - base), 32'd4);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
